// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART deframer with a single-entry valid/ready output buffer
module uart_receiver #(
    parameter int TICKS_PER_BAUD = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       framing_error_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW = (TICKS_PER_BAUD > 1) ? $clog2(TICKS_PER_BAUD) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(TICKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(TICKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, rx_s_q;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ovr_q, ovr_d;
    logic          byte_done;
    logic          frame_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    // Tick counter restarts at every sample point so each sample lands mid-bit.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (tick_q == HALF_M1) begin
                    tick_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d = '0;
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                tick_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                tick_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A drain and a load may coincide; the load wins and valid stays high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = frame_err;
        ovr_d   = 1'b0;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign data_o          = data_q;
    assign valid_o         = valid_q;
    assign framing_error_o = fe_q;
    assign overrun_o       = ovr_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed bench for uart_receiver against a frame-level model
module tb_uart_receiver;

    localparam int T = 4;
    // rx_i falling at edge n gives the byte (or framing error) after edge n + 41.
    localparam int LAT = 2 + T / 2 + 9 * T + 1;

    logic       clock;
    logic       reset_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       framing_error_o;
    logic       overrun_o;
    logic       busy_o;

    uart_receiver #(.TICKS_PER_BAUD(T)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx_i           (rx_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .framing_error_o(framing_error_o),
        .overrun_o      (overrun_o),
        .busy_o         (busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         e;
        logic       fe;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    ev_t        ev;
    int         edge_cnt = 0;
    int         last_start = 0;
    int         frames_started = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       chk_en = 1'b0;
    logic       rand_done = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;
    logic       arr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: each scheduled frame resolves at a fixed edge into the one-entry buffer.
    always @(posedge clock) begin
        edge_cnt = edge_cnt + 1;
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            arr = 1'b0;
            if (evq.size() > 0 && evq[0].e == edge_cnt) begin
                ev  = evq.pop_front();
                arr = 1'b1;
            end
            if (arr && ev.fe) m_fe = 1'b1;
            if (m_valid && ready_i) m_valid = 1'b0;
            if (arr && !ev.fe) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_data  = ev.b;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (!reset_n) begin
                check_eq("rst_valid", 32'(valid_o), 32'd0);
                check_eq("rst_data", 32'(data_o), 32'd0);
                check_eq("rst_fe", 32'(framing_error_o), 32'd0);
                check_eq("rst_ovr", 32'(overrun_o), 32'd0);
                check_eq("rst_busy", 32'(busy_o), 32'd0);
            end else begin
                check_eq("valid", 32'(valid_o), 32'(m_valid));
                if (m_valid) check_eq("data", 32'(data_o), 32'(m_data));
                check_eq("framing_error", 32'(framing_error_o), 32'(m_fe));
                check_eq("overrun", 32'(overrun_o), 32'(m_ovr));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            rx_i = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < T; j++) begin
                @(posedge clock);
                #1;
                if (j == 0) begin
                    rx_i = f[i];
                    if (i == 0) begin
                        last_start = edge_cnt;
                        frames_started++;
                        if (nbits == 10) evq.push_back('{edge_cnt + LAT, !stop_bit, b});
                    end
                end
            end
        end
    endtask

    initial begin
        int f0;
        int waited;
        logic [7:0] b;
        logic bad;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(8);

        ready_i = 1'b1;
        send(8'hA5, 1'b1, 10);
        idle(3 * T);

        @(posedge clock);
        #1;
        rx_i = 1'b0;
        @(posedge clock);
        #1;
        rx_i = 1'b1;
        idle(3 * T);
        check_eq("busy_after_glitch", 32'(busy_o), 32'd0);
        send(8'h3C, 1'b1, 10);
        idle(3 * T);

        send(8'h55, 1'b0, 10);
        for (int i = 0; i < 20 * T; i++) begin
            @(posedge clock);
            #1;
            rx_i = 1'b0;
        end
        check_eq("busy_in_break", 32'(busy_o), 32'd1);
        idle(3 * T);
        send(8'h81, 1'b1, 10);
        idle(3 * T);

        ready_i = 1'b0;
        send(8'h11, 1'b1, 10);
        send(8'h22, 1'b1, 10);
        idle(3 * T);
        check_eq("ovr_hold_data", 32'(data_o), 32'h11);
        @(posedge clock);
        #1;
        ready_i = 1'b1;
        @(posedge clock);
        #1;
        ready_i = 1'b0;
        check_eq("ovr_drained", 32'(valid_o), 32'd0);
        idle(2 * T);

        f0 = frames_started;
        fork
            begin
                send(8'h11, 1'b1, 10);
                send(8'h22, 1'b1, 10);
            end
            begin
                waited = 0;
                while (frames_started < f0 + 2 && waited < 400) begin
                    @(posedge clock);
                    #1;
                    waited++;
                end
                check_eq("swap_start_seen", 32'(frames_started >= f0 + 2), 32'd1);
                while (edge_cnt < last_start + LAT - 1 && waited < 800) begin
                    @(posedge clock);
                    #1;
                    waited++;
                end
                ready_i = 1'b1;
                @(posedge clock);
                #1;
                ready_i = 1'b0;
                check_eq("swap_data", 32'(data_o), 32'h22);
                check_eq("swap_valid", 32'(valid_o), 32'd1);
            end
        join
        idle(2 * T);
        ready_i = 1'b1;
        idle(2 * T);

        send(8'hF0, 1'b1, 6);
        @(posedge clock);
        #1;
        check_eq("busy_mid_frame", 32'(busy_o), 32'd1);
        reset_n = 1'b0;
        rx_i    = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(3 * T);
        send(8'h0F, 1'b1, 10);
        idle(3 * T);

        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    b   = 8'($urandom);
                    bad = ($urandom_range(0, 7) == 0);
                    send(b, !bad, 10);
                    if (bad) idle(T + int'($urandom_range(0, 4)));
                    else if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 6)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_i = 1'b1;
        idle(LAT + 4 * T);
        check_eq("final_valid", 32'(valid_o), 32'd0);
        check_eq("final_busy", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
